// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
package sevenseg_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam logic        ANODE_OFF = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Host-side bus of the digit scanner: control/value in, decoder feed and anodes out.
interface sevenseg_scan_if
  import sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
);

  logic                          en;
  logic                          load;
  logic [NIBBLE_W*NDIGITS-1:0]   value;
  logic [NIBBLE_W-1:0]           digit;
  logic [NDIGITS-1:0]            anode;
  logic                          blank;
  logic                          frame_done;

  modport master (
    output en, load, value,
    input  digit, anode, blank, frame_done
  );

  modport slave (
    input  en, load, value,
    output digit, anode, blank, frame_done
  );

endinterface

// File: rtl/sevenseg_slot_timer.sv
// Slot cycle counter and digit index with slot/frame end strobes.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned DIV     = 50000,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_cnt,
  output logic [IDX_W-1:0] o_idx_nxt_c,
  output logic             o_slot_end_c,
  output logic             o_frame_end_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_slot_end;
  logic             w_frame_end;

  // Counting stops and clears whenever the scanner is not running.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_W'(DIV - 1));
    w_frame_end = w_slot_end && (r_idx == IDX_W'(NDIGITS - 1));
    w_cnt_nxt   = '0;
    w_idx_nxt   = '0;
    if (i_run) begin
      if (w_slot_end) begin
        w_cnt_nxt = '0;
        w_idx_nxt = w_frame_end ? '0 : r_idx + IDX_W'(1);
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_idx_nxt = r_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  assign o_cnt         = r_cnt;
  assign o_idx_nxt_c   = w_idx_nxt;
  assign o_slot_end_c  = w_slot_end;
  assign o_frame_end_c = w_frame_end;

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed digit scanner with anode dead-time and frame-aligned value loads.
// Define SEVENSEG_LZB_EN to dark the anodes of leading-zero digits.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned DIV     = 50000,
  parameter int unsigned BLANK   = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  sevenseg_scan_if.slave  bus
);

  localparam int unsigned CNT_W      = clog2_min1(DIV);
  localparam int unsigned IDX_W      = clog2_min1(NDIGITS);
  localparam int unsigned VAL_W      = NIBBLE_W * NDIGITS;
  localparam int unsigned BLANK_LAST = (BLANK == 0) ? 0 : BLANK - 1;

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [CNT_W-1:0]    w_cnt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_slot_end;
  logic                w_frame_end;
  logic                w_run;
  logic                w_frame_bnd;
  logic [VAL_W-1:0]    r_active;
  logic [VAL_W-1:0]    r_pending;
  logic                r_pend_vld;
  logic [VAL_W-1:0]    w_active_nxt;
  logic [VAL_W-1:0]    w_pending_nxt;
  logic                w_pend_vld_nxt;
  logic [NIBBLE_W-1:0] w_sel_nib;
  logic [NDIGITS-1:0]  w_onehot;
  logic                w_lzb_dark;
  logic [NIBBLE_W-1:0] r_digit;
  logic [NIBBLE_W-1:0] w_digit_nxt;
  logic [NDIGITS-1:0]  r_anode;
  logic [NDIGITS-1:0]  w_anode_nxt;
  logic                r_blank;
  logic                w_blank_nxt;
  logic                r_frame_done;
  logic                w_frame_done_nxt;

  // Asynchronous assertion, release aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_run       = (r_state != S_IDLE) && bus.en;
  assign w_frame_bnd = (r_state == S_DRIVE) && bus.en && w_frame_end;

  sevenseg_slot_timer #(
    .NDIGITS (NDIGITS),
    .DIV     (DIV),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .i_run         (w_run),
    .o_cnt         (w_cnt),
    .o_idx_nxt_c   (w_idx_nxt),
    .o_slot_end_c  (w_slot_end),
    .o_frame_end_c (w_frame_end)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.en) w_state_nxt = (BLANK == 0) ? S_DRIVE : S_BLANK;
      end
      S_BLANK: begin
        if (!bus.en)                            w_state_nxt = S_IDLE;
        else if (w_cnt == CNT_W'(BLANK_LAST))   w_state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        if (!bus.en)         w_state_nxt = S_IDLE;
        else if (w_slot_end) w_state_nxt = (BLANK == 0) ? S_DRIVE : S_BLANK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Displayed value only changes while idle or at a frame wrap; a coincident load wins.
  always_comb begin
    w_active_nxt   = r_active;
    w_pending_nxt  = r_pending;
    w_pend_vld_nxt = r_pend_vld;
    if (bus.load && (r_state == S_IDLE)) begin
      w_active_nxt = bus.value;
    end else if (w_frame_bnd) begin
      if (bus.load)        w_active_nxt = bus.value;
      else if (r_pend_vld) w_active_nxt = r_pending;
      w_pend_vld_nxt = 1'b0;
    end else if (bus.load) begin
      w_pending_nxt  = bus.value;
      w_pend_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_active   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  always_comb begin
    w_sel_nib = '0;
    w_onehot  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_sel_nib   = w_active_nxt[i*NIBBLE_W +: NIBBLE_W];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEVENSEG_LZB_EN
  logic [IDX_W-1:0] w_hi_idx;

  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_active_nxt[i*NIBBLE_W +: NIBBLE_W] != '0) w_hi_idx = IDX_W'(i);
    end
  end
  assign w_lzb_dark = (w_idx_nxt > w_hi_idx);
`else
  assign w_lzb_dark = 1'b0;
`endif

  // Outputs are decoded from the post-edge state so they line up with the counters.
  always_comb begin
    w_digit_nxt      = '0;
    w_anode_nxt      = {NDIGITS{ANODE_OFF}};
    w_blank_nxt      = 1'b1;
    w_frame_done_nxt = w_frame_bnd;
    case (w_state_nxt)
      S_BLANK: begin
        w_digit_nxt = w_sel_nib;
      end
      S_DRIVE: begin
        w_digit_nxt = w_sel_nib;
        if (!w_lzb_dark) begin
          w_anode_nxt = w_onehot;
          w_blank_nxt = 1'b0;
        end
      end
      default: begin
        w_digit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_digit      <= '0;
      r_anode      <= {NDIGITS{ANODE_OFF}};
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_digit      <= w_digit_nxt;
      r_anode      <= w_anode_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.digit      = r_digit;
  assign bus.anode      = r_anode;
  assign bus.blank      = r_blank;
  assign bus.frame_done = r_frame_done;

endmodule
